// File: rtl/sm83_pkg.sv
// ---------------------------------------------------------------------------
// sm83_pkg
// Shared types for the SM83 core slice: ALU operation codes, 8-bit register
// selects, register write-enable vector, the ALU sequencer state enum, and
// the opcode classes produced by the ALU decoder.
// Helper functions map the 3-bit opcode fields onto register selects and
// ALU operations.
// ---------------------------------------------------------------------------
package sm83_pkg;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_ADC = 4'd2,
        ALU_SUB = 4'd3,
        ALU_SBC = 4'd4,
        ALU_AND = 4'd5,
        ALU_XOR = 4'd6,
        ALU_OR  = 4'd7,
        ALU_CP  = 4'd8,
        ALU_INC = 4'd9,
        ALU_DEC = 4'd10
    } alu_op_t;

    // Encoded exactly like the r8 opcode field; code 6 is the (HL) slot,
    // which is not a register and never reaches the register file.
    typedef enum logic [2:0] {
        GP_B      = 3'd0,
        GP_C      = 3'd1,
        GP_D      = 3'd2,
        GP_E      = 3'd3,
        GP_H      = 3'd4,
        GP_L      = 3'd5,
        GP_HL_IND = 3'd6,
        GP_A      = 3'd7
    } gp_r8_sel_t;

    // gp8 writes the register named by dst_sel; a and f are the accumulator
    // and the flag register.
    typedef struct packed {
        logic a;
        logic f;
        logic gp8;
    } reg_wen_vec_t;

    typedef enum logic [2:0] {
        SEQ_FETCH    = 3'd0,
        SEQ_DECODE   = 3'd1,
        SEQ_READ_IMM = 3'd2,
        SEQ_READ_HL  = 3'd3,
        SEQ_EXEC     = 3'd4,
        SEQ_FAULT    = 3'd5
    } seq_state_t;

    typedef enum logic [2:0] {
        OPC_NOP     = 3'd0,
        OPC_ALU_REG = 3'd1,
        OPC_ALU_HL  = 3'd2,
        OPC_ALU_IMM = 3'd3,
        OPC_INCDEC  = 3'd4,
        OPC_ILLEGAL = 3'd5
    } opc_class_t;

    // Operand source kinds seen by the datapath operand mux.
    localparam logic [1:0] SRC_KIND_GP8 = 2'd0;
    localparam logic [1:0] SRC_KIND_A   = 2'd1;
    localparam logic [1:0] SRC_KIND_MEM = 2'd2;

    function automatic gp_r8_sel_t gp_r8_from_bits(input logic [2:0] code);
        gp_r8_sel_t sel;
        case (code)
            3'd0:    sel = GP_B;
            3'd1:    sel = GP_C;
            3'd2:    sel = GP_D;
            3'd3:    sel = GP_E;
            3'd4:    sel = GP_H;
            3'd5:    sel = GP_L;
            3'd6:    sel = GP_HL_IND;
            default: sel = GP_A;
        endcase
        return sel;
    endfunction

    function automatic alu_op_t alu_op_from_bits(input logic [2:0] code);
        alu_op_t op;
        case (code)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_ADC;
            3'd2:    op = ALU_SUB;
            3'd3:    op = ALU_SBC;
            3'd4:    op = ALU_AND;
            3'd5:    op = ALU_XOR;
            3'd6:    op = ALU_OR;
            default: op = ALU_CP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sm83_alu_decode.sv
// ---------------------------------------------------------------------------
// sm83_alu_decode
// Combinational classifier for the 8-bit ALU instruction subset.
// Ports:
//   ir       in   opcode
//   op_class out  opcode class (NOP, ALU reg/(HL)/imm, INC/DEC, illegal)
//   alu_op   out  ALU operation for the opcode (ALU_NOP when not an ALU op)
//   src_sel  out  operand source register
//   dst_sel  out  destination register
// ---------------------------------------------------------------------------
module sm83_alu_decode
    import sm83_pkg::*;
(
    input  logic [7:0]  ir,
    output opc_class_t  op_class,
    output alu_op_t     alu_op,
    output gp_r8_sel_t  src_sel,
    output gp_r8_sel_t  dst_sel
);

    // Classify the opcode. ALU ops always target A; INC/DEC read and write
    // the same register. INC/DEC (HL) is a read-modify-write this block does
    // not sequence, so it falls through to the illegal class.
    always_comb begin
        op_class = OPC_ILLEGAL;
        alu_op   = ALU_NOP;
        src_sel  = GP_A;
        dst_sel  = GP_A;

        if (ir == 8'h00) begin
            op_class = OPC_NOP;
        end else if (ir[7:6] == 2'b10) begin
            alu_op   = alu_op_from_bits(ir[5:3]);
            src_sel  = gp_r8_from_bits(ir[2:0]);
            op_class = (ir[2:0] == 3'd6) ? OPC_ALU_HL : OPC_ALU_REG;
        end else if (ir[7:6] == 2'b11 && ir[2:0] == 3'b110) begin
            alu_op   = alu_op_from_bits(ir[5:3]);
            op_class = OPC_ALU_IMM;
        end else if (ir[7:6] == 2'b00 && ir[2:1] == 2'b10 && ir[5:3] != 3'd6) begin
            alu_op   = ir[0] ? ALU_DEC : ALU_INC;
            src_sel  = gp_r8_from_bits(ir[5:3]);
            dst_sel  = gp_r8_from_bits(ir[5:3]);
            op_class = OPC_INCDEC;
        end
    end

endmodule

// File: rtl/sm83_alu_seq.sv
// ---------------------------------------------------------------------------
// sm83_alu_seq
// Instruction sequencer for the SM83 8-bit ALU subset: fetches the opcode,
// optionally reads an immediate or (HL) operand, then issues one EXEC cycle
// with ALU operation, operand selects and register write enables.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   mem_req/mem_addr     read request and address (held until mem_ack)
//   mem_ack/mem_rdata    one-cycle acknowledge with read data
//   pc, hl, ir           register file values
//   ir_load, pc_inc      one-cycle register file strobes
//   alu_op, src_sel, dst_sel, src_kind, mem_latch, reg_wen
//                        EXEC-cycle datapath controls
//   instr_done           pulse in the last cycle of each instruction
//   fault                high once an unsupported opcode is decoded
// ---------------------------------------------------------------------------
module sm83_alu_seq
    import sm83_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    output logic         mem_req,
    output logic [15:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [7:0]   mem_rdata,
    input  logic [15:0]  pc,
    input  logic [15:0]  hl,
    input  logic [7:0]   ir,
    output logic         ir_load,
    output logic         pc_inc,
    output alu_op_t      alu_op,
    output gp_r8_sel_t   src_sel,
    output gp_r8_sel_t   dst_sel,
    output logic [1:0]   src_kind,
    output logic [7:0]   mem_latch,
    output reg_wen_vec_t reg_wen,
    output logic         instr_done,
    output logic         fault
);

    seq_state_t state;
    seq_state_t next_state;
    opc_class_t dec_class;
    alu_op_t    dec_op;
    gp_r8_sel_t dec_src;
    gp_r8_sel_t dec_dst;
    logic       req_state;
    logic       accept;
    logic       latch_en;

    sm83_alu_decode u_decode (
        .ir       (ir),
        .op_class (dec_class),
        .alu_op   (dec_op),
        .src_sel  (dec_src),
        .dst_sel  (dec_dst)
    );

    // The reset term makes mem_req drop the moment rst rises, even though the
    // reset state (FETCH) is itself a requesting state. An acknowledge only
    // counts while a request is actually being presented.
    assign req_state = (state == SEQ_FETCH) || (state == SEQ_READ_IMM) ||
                       (state == SEQ_READ_HL);
    assign mem_req   = req_state && !rst;
    assign accept    = mem_req && mem_ack;

    // Selects follow the decoder continuously; they only matter in EXEC,
    // where alu_op and reg_wen qualify them.
    assign src_sel  = dec_src;
    assign dst_sel  = dec_dst;
    assign src_kind = (dec_class == OPC_ALU_HL || dec_class == OPC_ALU_IMM) ? SRC_KIND_MEM :
                      (dec_src == GP_A)                                     ? SRC_KIND_A   :
                                                                              SRC_KIND_GP8;

    // State register and the memory operand latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEQ_FETCH;
            mem_latch <= 8'h00;
        end else begin
            state <= next_state;
            if (latch_en) begin
                mem_latch <= mem_rdata;
            end
        end
    end

    // Next-state and per-state strobes. Only the immediate read advances PC
    // past the opcode; the (HL) read leaves PC alone.
    always_comb begin
        next_state = state;
        mem_addr   = pc;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        latch_en   = 1'b0;
        alu_op     = ALU_NOP;
        reg_wen    = '0;
        instr_done = 1'b0;
        fault      = 1'b0;

        case (state)
            SEQ_FETCH: begin
                mem_addr = pc;
                if (accept) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = SEQ_DECODE;
                end
            end
            SEQ_DECODE: begin
                case (dec_class)
                    OPC_NOP,
                    OPC_ALU_REG,
                    OPC_INCDEC:  next_state = SEQ_EXEC;
                    OPC_ALU_HL:  next_state = SEQ_READ_HL;
                    OPC_ALU_IMM: next_state = SEQ_READ_IMM;
                    default:     next_state = SEQ_FAULT;
                endcase
            end
            SEQ_READ_IMM: begin
                mem_addr = pc;
                if (accept) begin
                    latch_en   = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = SEQ_EXEC;
                end
            end
            SEQ_READ_HL: begin
                mem_addr = hl;
                if (accept) begin
                    latch_en   = 1'b1;
                    next_state = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                alu_op     = dec_op;
                instr_done = 1'b1;
                next_state = SEQ_FETCH;
                case (dec_class)
                    OPC_ALU_REG,
                    OPC_ALU_HL,
                    OPC_ALU_IMM: begin
                        reg_wen.f = 1'b1;
                        reg_wen.a = (dec_op != ALU_CP);
                    end
                    OPC_INCDEC: begin
                        reg_wen.f   = 1'b1;
                        reg_wen.a   = (dec_dst == GP_A);
                        reg_wen.gp8 = (dec_dst != GP_A);
                    end
                    default: begin
                        reg_wen = '0;
                    end
                endcase
            end
            SEQ_FAULT: begin
                fault      = 1'b1;
                next_state = SEQ_FAULT;
            end
            default: begin
                next_state = SEQ_FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_sm83_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_sm83_alu_seq
// Directed bench for sm83_alu_seq with a byte memory, a configurable-wait
// acknowledge responder and a minimal register file (PC/IR) model.
// ---------------------------------------------------------------------------
module tb_sm83_alu_seq;
    import sm83_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_req;
    logic [15:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [7:0]   mem_rdata = 8'h00;
    logic [15:0]  pc = 16'h0000;
    logic [15:0]  hl = 16'h0000;
    logic [7:0]   ir = 8'h00;
    logic         ir_load;
    logic         pc_inc;
    alu_op_t      alu_op;
    gp_r8_sel_t   src_sel;
    gp_r8_sel_t   dst_sel;
    logic [1:0]   src_kind;
    logic [7:0]   mem_latch;
    reg_wen_vec_t reg_wen;
    logic         instr_done;
    logic         fault;

    logic [7:0]   mem [0:65535];
    logic [15:0]  pc_preset = 16'h0000;
    int           ack_delay = 0;
    logic         spurious_ack = 1'b0;
    int           wait_cnt = 0;

    int           cyc = 0;
    int           ir_load_cnt = 0;
    int           pc_inc_cnt = 0;
    int           done_cnt = 0;
    int           first_ir_load = 0;
    int           done_cyc = 0;
    int           hold_cnt = 0;
    logic [15:0]  hold_addr = 16'h0000;
    logic [15:0]  acc_addr [$];
    alu_op_t      rec_op = ALU_NOP;
    gp_r8_sel_t   rec_src = GP_B;
    gp_r8_sel_t   rec_dst = GP_B;
    logic [1:0]   rec_kind = 2'd0;
    logic [7:0]   rec_latch = 8'h00;
    reg_wen_vec_t rec_wen = '0;

    int           nChecks = 0;
    int           nErrors = 0;

    sm83_alu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc         (pc),
        .hl         (hl),
        .ir         (ir),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .alu_op     (alu_op),
        .src_sel    (src_sel),
        .dst_sel    (dst_sel),
        .src_kind   (src_kind),
        .mem_latch  (mem_latch),
        .reg_wen    (reg_wen),
        .instr_done (instr_done),
        .fault      (fault)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Acknowledge responder: settles 1 unit after each edge (or reset
    // release) and acks after ack_delay idle cycles of an open request.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (rst) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (spurious_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hAA;
            end else if (mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wait_cnt  = 0;
                end else begin
                    mem_ack  = 1'b0;
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Register file model and event recorder, sampled on the clock edge
    // with pre-edge values. Cycle k is the cycle ending at the k-th edge
    // after reset release.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pc            = pc_preset;
                ir            = 8'h00;
                cyc           = 0;
                ir_load_cnt   = 0;
                pc_inc_cnt    = 0;
                done_cnt      = 0;
                first_ir_load = 0;
                done_cyc      = 0;
                hold_cnt      = 0;
                acc_addr.delete();
            end else begin
                cyc = cyc + 1;
                if (mem_req && mem_addr == hold_addr) hold_cnt = hold_cnt + 1;
                if (mem_req && mem_ack) acc_addr.push_back(mem_addr);
                if (instr_done) begin
                    done_cnt  = done_cnt + 1;
                    done_cyc  = cyc;
                    rec_op    = alu_op;
                    rec_src   = src_sel;
                    rec_dst   = dst_sel;
                    rec_kind  = src_kind;
                    rec_latch = mem_latch;
                    rec_wen   = reg_wen;
                end
                if (ir_load) begin
                    ir          = mem_rdata;
                    ir_load_cnt = ir_load_cnt + 1;
                    if (first_ir_load == 0) first_ir_load = cyc;
                end
                if (pc_inc) begin
                    pc         = pc + 16'd1;
                    pc_inc_cnt = pc_inc_cnt + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks = nChecks + 1;
        if (got !== exp) begin
            nErrors = nErrors + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for instr_done or fault, then one more cycle so the
    // recorder has captured the final edge.
    task automatic waitDone(input string tag, input int budget);
        int n;
        n = 0;
        while (!instr_done && !fault && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput({tag, "_finished"}, {31'd0, (instr_done | fault)}, 32'd1);
        @(negedge clk);
    endtask

    // Reset with a new PC and ack delay, release on a falling edge, run one
    // instruction.
    task automatic applyStimulus(input string tag, input logic [15:0] start_pc, input int delay);
        pc_preset = start_pc;
        ack_delay = delay;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        waitDone(tag, 60);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'h80;
        mem[16'h0200] = 8'hFE;  mem[16'h0201] = 8'h42;
        mem[16'h0300] = 8'h86;  mem[16'hC000] = 8'h5A;
        mem[16'h0380] = 8'h91;
        mem[16'h03C0] = 8'hBF;
        mem[16'h03E0] = 8'hC6;  mem[16'h03E1] = 8'h10;
        mem[16'h0400] = 8'h3C;
        mem[16'h0440] = 8'h05;
        mem[16'h0480] = 8'h00;
        mem[16'h0500] = 8'h34;
        mem[16'h0600] = 8'hFE;  mem[16'h0601] = 8'h77;
        mem[16'h0700] = 8'h80;

        // Reset state, sampled mid-reset.
        @(posedge clk);
        #1;
        checkOutput("rst_mem_req",    {31'd0, mem_req},    32'd0);
        checkOutput("rst_ir_load",    {31'd0, ir_load},    32'd0);
        checkOutput("rst_pc_inc",     {31'd0, pc_inc},     32'd0);
        checkOutput("rst_instr_done", {31'd0, instr_done}, 32'd0);
        checkOutput("rst_fault",      {31'd0, fault},      32'd0);
        checkOutput("rst_mem_latch",  {24'd0, mem_latch},  32'h00);
        checkOutput("rst_alu_op",     {28'd0, alu_op},     {28'd0, ALU_NOP});
        checkOutput("rst_reg_wen",    {29'd0, reg_wen},    32'd0);

        // ADD A,B with zero-wait memory.
        applyStimulus("add_b", 16'h0100, 0);
        checkOutput("add_b_ir_load_cyc", first_ir_load, 1);
        checkOutput("add_b_done_cyc",    done_cyc, 3);
        checkOutput("add_b_fetch_addr",  {16'd0, acc_addr[0]}, 32'h0100);
        checkOutput("add_b_op",          {28'd0, rec_op},  {28'd0, ALU_ADD});
        checkOutput("add_b_src",         {29'd0, rec_src}, {29'd0, GP_B});
        checkOutput("add_b_kind",        {30'd0, rec_kind}, 32'd0);
        checkOutput("add_b_wen",         {29'd0, rec_wen}, 32'b110);
        checkOutput("add_b_pc_inc",      pc_inc_cnt, 1);
        checkOutput("add_b_done_cnt",    done_cnt, 1);

        // CP 0x42 with three wait cycles on every access.
        hold_addr = 16'h0201;
        applyStimulus("cp_imm", 16'h0200, 3);
        checkOutput("cp_imm_ir_load_cyc", first_ir_load, 4);
        checkOutput("cp_imm_hold_cycles", hold_cnt, 4);
        checkOutput("cp_imm_done_cyc",    done_cyc, 10);
        checkOutput("cp_imm_latch",       {24'd0, rec_latch}, 32'h42);
        checkOutput("cp_imm_op",          {28'd0, rec_op}, {28'd0, ALU_CP});
        checkOutput("cp_imm_wen",         {29'd0, rec_wen}, 32'b010);
        checkOutput("cp_imm_kind",        {30'd0, rec_kind}, 32'd2);
        checkOutput("cp_imm_pc_inc",      pc_inc_cnt, 2);
        checkOutput("cp_imm_pc",          {16'd0, pc}, 32'h0202);
        hold_addr = 16'h0000;

        // ADD A,(HL).
        hl = 16'hC000;
        applyStimulus("add_hl", 16'h0300, 0);
        checkOutput("add_hl_rd_addr", {16'd0, acc_addr[1]}, 32'hC000);
        checkOutput("add_hl_done_cyc", done_cyc, 4);
        checkOutput("add_hl_pc_inc",  pc_inc_cnt, 1);
        checkOutput("add_hl_kind",    {30'd0, rec_kind}, 32'd2);
        checkOutput("add_hl_op",      {28'd0, rec_op}, {28'd0, ALU_ADD});
        checkOutput("add_hl_latch",   {24'd0, rec_latch}, 32'h5A);
        checkOutput("add_hl_wen",     {29'd0, rec_wen}, 32'b110);

        // SUB C, CP A and ADD A,imm with zero wait.
        applyStimulus("sub_c", 16'h0380, 0);
        checkOutput("sub_c_op",   {28'd0, rec_op}, {28'd0, ALU_SUB});
        checkOutput("sub_c_src",  {29'd0, rec_src}, {29'd0, GP_C});
        applyStimulus("cp_a", 16'h03C0, 0);
        checkOutput("cp_a_kind",  {30'd0, rec_kind}, 32'd1);
        checkOutput("cp_a_wen",   {29'd0, rec_wen}, 32'b010);
        applyStimulus("add_imm", 16'h03E0, 0);
        checkOutput("add_imm_done_cyc", done_cyc, 4);
        checkOutput("add_imm_latch",    {24'd0, rec_latch}, 32'h10);

        // INC A and DEC B.
        applyStimulus("inc_a", 16'h0400, 0);
        checkOutput("inc_a_op",  {28'd0, rec_op}, {28'd0, ALU_INC});
        checkOutput("inc_a_src", {29'd0, rec_src}, {29'd0, GP_A});
        checkOutput("inc_a_dst", {29'd0, rec_dst}, {29'd0, GP_A});
        checkOutput("inc_a_wen", {29'd0, rec_wen}, 32'b110);
        applyStimulus("dec_b", 16'h0440, 0);
        checkOutput("dec_b_op",  {28'd0, rec_op}, {28'd0, ALU_DEC});
        checkOutput("dec_b_dst", {29'd0, rec_dst}, {29'd0, GP_B});
        checkOutput("dec_b_wen", {29'd0, rec_wen}, 32'b011);

        // NOP.
        applyStimulus("nop", 16'h0480, 0);
        checkOutput("nop_op",       {28'd0, rec_op}, {28'd0, ALU_NOP});
        checkOutput("nop_wen",      {29'd0, rec_wen}, 32'd0);
        checkOutput("nop_done_cyc", done_cyc, 3);

        // INC (HL) faults; a stray ack while idle must be ignored.
        applyStimulus("inc_hl", 16'h0500, 0);
        checkOutput("inc_hl_fault", {31'd0, fault}, 32'd1);
        spurious_ack = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("fault_mem_ack_seen", {31'd0, mem_ack}, 32'd1);
        checkOutput("fault_mem_req",      {31'd0, mem_req}, 32'd0);
        checkOutput("fault_hold",         {31'd0, fault},   32'd1);
        checkOutput("fault_ir_load_cnt",  ir_load_cnt, 1);
        checkOutput("fault_pc_inc_cnt",   pc_inc_cnt, 1);
        checkOutput("fault_done_cnt",     done_cnt, 0);
        spurious_ack = 1'b0;

        // Reset in the middle of a waiting immediate read.
        pc_preset = 16'h0600;
        ack_delay = 3;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 20 && ir_load_cnt == 0; n++) @(negedge clk);
        @(posedge clk);
        #2;
        checkOutput("midrst_pre_req",  {31'd0, mem_req}, 32'd1);
        checkOutput("midrst_pre_addr", {16'd0, mem_addr}, 32'h0601);
        pc_preset = 16'h0700;
        ack_delay = 0;
        rst       = 1'b1;
        #1;
        checkOutput("midrst_req_drop", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_new_req",  {31'd0, mem_req}, 32'd1);
        checkOutput("midrst_new_addr", {16'd0, mem_addr}, 32'h0700);
        waitDone("midrst", 60);
        checkOutput("midrst_op",       {28'd0, rec_op}, {28'd0, ALU_ADD});
        checkOutput("midrst_done_cyc", done_cyc, 3);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
